// File: rtl/nes_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : nes_pkg
//  Description : Shared types and defaults for the NES-style OAM DMA block:
//                DMA state encoding, default register/port addresses and a
//                helper that forms the in-page source address.
//  Revision    : 1.0  initial release
// ============================================================================
package nes_pkg;

  // DMA sequencer states.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HALT  = 3'd1,
    ST_ALIGN = 3'd2,
    ST_READ  = 3'd3,
    ST_WRITE = 3'd4
  } dma_state_e;

  // CPU write address that launches a DMA burst.
  localparam logic [15:0] DMA_REG_ADDR_DEFAULT  = 16'h4014;
  // PPU OAM data port that receives every DMA byte.
  localparam logic [15:0] OAM_DATA_ADDR_DEFAULT = 16'h2004;
  // Bytes moved per burst.
  localparam int          XFER_LEN_DEFAULT      = 256;

  // Source address is page:index; the index never carries into the page.
  function automatic logic [15:0] dma_src_addr(input logic [7:0] page,
                                               input logic [7:0] idx);
    return {page, idx};
  endfunction

  // The DMA owns the shared bus in every state except IDLE.
  function automatic logic dma_owns_bus(input dma_state_e st);
    return (st != ST_IDLE);
  endfunction

endpackage
`default_nettype wire

// File: rtl/cpu_bus_mux.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_bus_mux
//  Description : Shared memory bus ownership mux. When i_dma_sel is low the
//                CPU side passes straight through to the bus and bus read
//                data returns to the CPU. When high, the DMA side drives the
//                bus and the CPU sees zero read data (it is halted anyway).
//  Ports       : i_dma_sel                         - 1 selects DMA side
//                i_cpu_addr/wdata/ren/wen, o_cpu_rdata - CPU side
//                i_dma_addr/wdata/ren/wen           - DMA side
//                o_bus_addr/wdata/ren/wen, i_bus_rdata - shared bus side
//  Revision    : 1.0  initial release
// ============================================================================
module cpu_bus_mux (
  input  logic        i_dma_sel,
  // CPU side
  input  logic [15:0] i_cpu_addr,
  input  logic [7:0]  i_cpu_wdata,
  input  logic        i_cpu_ren,
  input  logic        i_cpu_wen,
  output logic [7:0]  o_cpu_rdata,
  // DMA side
  input  logic [15:0] i_dma_addr,
  input  logic [7:0]  i_dma_wdata,
  input  logic        i_dma_ren,
  input  logic        i_dma_wen,
  // Shared bus side
  output logic [15:0] o_bus_addr,
  output logic [7:0]  o_bus_wdata,
  output logic        o_bus_ren,
  output logic        o_bus_wen,
  input  logic [7:0]  i_bus_rdata
);

  always_comb begin
    if (i_dma_sel) begin
      o_bus_addr  = i_dma_addr;
      o_bus_wdata = i_dma_wdata;
      o_bus_ren   = i_dma_ren;
      o_bus_wen   = i_dma_wen;
      o_cpu_rdata = 8'h00;
    end else begin
      o_bus_addr  = i_cpu_addr;
      o_bus_wdata = i_cpu_wdata;
      o_bus_ren   = i_cpu_ren;
      o_bus_wen   = i_cpu_wen;
      o_cpu_rdata = i_bus_rdata;
    end
  end

endmodule
`default_nettype wire

// File: rtl/oam_dma_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : oam_dma_ctrl
//  Description : NES-style sprite (OAM) DMA controller. A CPU write to
//                DMA_REG_ADDR latches a source page and halts the CPU; the
//                block then copies XFER_LEN bytes from {page,idx} to the
//                OAM data port, one read and one write per bus cycle
//                (cyc_en). An extra ALIGN cycle is inserted when the burst
//                starts on an odd bus cycle.
//  Ports       : clk, rst (async, active-low), cyc_en (bus-cycle strobe)
//                cpu_addr/wdata/ren/wen -> CPU request, cpu_rdata/cpu_rdy back
//                bus_addr/wdata/ren/wen -> shared bus, bus_rdata back
//                dma_busy               -> high while a burst is in progress
//  Revision    : 1.0  initial release
// ============================================================================
module oam_dma_ctrl
  import nes_pkg::*;
#(
  parameter logic [15:0] DMA_REG_ADDR  = DMA_REG_ADDR_DEFAULT,
  parameter logic [15:0] OAM_DATA_ADDR = OAM_DATA_ADDR_DEFAULT,
  parameter int          XFER_LEN      = XFER_LEN_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cyc_en,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  input  logic        cpu_ren,
  input  logic        cpu_wen,
  output logic [7:0]  cpu_rdata,
  output logic        cpu_rdy,
  output logic [15:0] bus_addr,
  output logic [7:0]  bus_wdata,
  output logic        bus_ren,
  output logic        bus_wen,
  input  logic [7:0]  bus_rdata,
  output logic        dma_busy
);

  // Index value of the final byte; compared against the 8-bit index.
  localparam logic [7:0] LAST_IDX = 8'(XFER_LEN - 1);

  dma_state_e state_q, state_d;
  logic [7:0] page_q,  page_d;
  logic [7:0] idx_q,   idx_d;
  logic [7:0] data_q,  data_d;
  logic       parity_q, parity_d;
  logic       busy_q,   busy_d;

  logic        trigger;
  logic        dma_sel;
  logic [15:0] dma_addr;
  logic [7:0]  dma_wdata;
  logic        dma_ren;
  logic        dma_wen;

  assign trigger = cpu_wen && (cpu_addr == DMA_REG_ADDR);
  assign dma_sel = dma_owns_bus(state_q);

  // --------------------------------------------------------------------------
  // Next-state logic. Nothing moves unless cyc_en marks a bus cycle.
  // --------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    page_d   = page_q;
    idx_d    = idx_q;
    data_d   = data_q;
    parity_d = parity_q;

    if (cyc_en) begin
      // Free-running cycle parity decides whether an ALIGN cycle is needed.
      parity_d = ~parity_q;

      unique case (state_q)
        ST_IDLE: begin
          // The triggering write still reaches the bus through the mux.
          if (trigger) begin
            page_d  = cpu_wdata;
            idx_d   = 8'h00;
            state_d = ST_HALT;
          end
        end
        ST_HALT: begin
          state_d = parity_q ? ST_ALIGN : ST_READ;
        end
        ST_ALIGN: begin
          state_d = ST_READ;
        end
        ST_READ: begin
          data_d  = bus_rdata;
          state_d = ST_WRITE;
        end
        ST_WRITE: begin
          // 8-bit increment: the index wraps inside the page, never carries.
          idx_d   = idx_q + 8'd1;
          state_d = (idx_q == LAST_IDX) ? ST_IDLE : ST_READ;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    busy_d = (state_d != ST_IDLE);
  end

  // --------------------------------------------------------------------------
  // State and datapath registers.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      page_q   <= 8'h00;
      idx_q    <= 8'h00;
      data_q   <= 8'h00;
      parity_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      page_q   <= page_d;
      idx_q    <= idx_d;
      data_q   <= data_d;
      parity_q <= parity_d;
      busy_q   <= busy_d;
    end
  end

  // --------------------------------------------------------------------------
  // DMA-side bus request. Strobes are qualified by cyc_en so that the shared
  // bus never sees a DMA access outside a real bus cycle.
  // --------------------------------------------------------------------------
  always_comb begin
    dma_addr  = dma_src_addr(page_q, idx_q);
    dma_wdata = data_q;
    dma_ren   = 1'b0;
    dma_wen   = 1'b0;
    unique case (state_q)
      ST_READ: begin
        dma_ren = cyc_en;
      end
      ST_WRITE: begin
        dma_addr = OAM_DATA_ADDR;
        dma_wen  = cyc_en;
      end
      default: begin
        dma_ren = 1'b0;
      end
    endcase
  end

  cpu_bus_mux u_bus_mux (
    .i_dma_sel   (dma_sel),
    .i_cpu_addr  (cpu_addr),
    .i_cpu_wdata (cpu_wdata),
    .i_cpu_ren   (cpu_ren),
    .i_cpu_wen   (cpu_wen),
    .o_cpu_rdata (cpu_rdata),
    .i_dma_addr  (dma_addr),
    .i_dma_wdata (dma_wdata),
    .i_dma_ren   (dma_ren),
    .i_dma_wen   (dma_wen),
    .o_bus_addr  (bus_addr),
    .o_bus_wdata (bus_wdata),
    .o_bus_ren   (bus_ren),
    .o_bus_wen   (bus_wen),
    .i_bus_rdata (bus_rdata)
  );

  // The CPU is held for exactly as long as the DMA owns the bus.
  assign cpu_rdy  = ~busy_q;
  assign dma_busy = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_oam_dma_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_oam_dma_ctrl
//  Description : Directed self-checking bench for oam_dma_ctrl. Memory read
//                data is a fixed function of the bus address so every OAM
//                write byte can be predicted from its source address.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_oam_dma_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        cyc_en;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_ren;
  logic        cpu_wen;
  logic [7:0]  cpu_rdata;
  logic        cpu_rdy;
  logic [15:0] bus_addr;
  logic [7:0]  bus_wdata;
  logic        bus_ren;
  logic        bus_wen;
  logic [7:0]  bus_rdata;
  logic        dma_busy;

  int   errors = 0;
  int   checks = 0;
  logic par_m  = 1'b0;   // expected DUT cycle parity after the pending edge

  always #5 clk = ~clk;

  function automatic logic [7:0] mem_f(input logic [15:0] a);
    return a[15:8] ^ {a[6:0], a[7]} ^ 8'h3C;
  endfunction

  assign bus_rdata = mem_f(bus_addr);

  oam_dma_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .cyc_en    (cyc_en),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_ren   (cpu_ren),
    .cpu_wen   (cpu_wen),
    .cpu_rdata (cpu_rdata),
    .cpu_rdy   (cpu_rdy),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_ren   (bus_ren),
    .bus_wen   (bus_wen),
    .bus_rdata (bus_rdata),
    .dma_busy  (dma_busy)
  );

  // Drive one clock's worth of inputs at the falling edge, then settle.
  task automatic drive_cycle(input logic en, input logic [15:0] a,
                             input logic [7:0] wd, input logic r, input logic w);
    @(negedge clk);
    cyc_en    = en;
    cpu_addr  = a;
    cpu_wdata = wd;
    cpu_ren   = r;
    cpu_wen   = w;
    if (en) par_m = ~par_m;
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b0; cyc_en = 1'b0;
    cpu_addr = 16'h1234; cpu_wdata = 8'h5A; cpu_ren = 1'b1; cpu_wen = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (cpu_rdy !== 1'b1 || dma_busy !== 1'b0)
      $display("FAIL reset_flags: cpu_rdy=%b dma_busy=%b required 1 0", cpu_rdy, dma_busy);
    if (cpu_rdy !== 1'b1 || dma_busy !== 1'b0) errors++;
    checks++;
    if (bus_addr !== 16'h1234 || bus_wdata !== 8'h5A || bus_ren !== 1'b1 || bus_wen !== 1'b0) begin
      errors++;
      $display("FAIL reset_mirror: addr=%h wdata=%h ren=%b wen=%b required 1234 5a 1 0",
               bus_addr, bus_wdata, bus_ren, bus_wen);
    end
    checks++;
    if (cpu_rdata !== mem_f(16'h1234)) begin
      errors++;
      $display("FAIL reset_rdata: got=%h required=%h", cpu_rdata, mem_f(16'h1234));
    end
    @(negedge clk);
    rst = 1'b1; cpu_ren = 1'b0; par_m = 1'b0;
  endtask

  task automatic test_passthrough;
    drive_cycle(1'b1, 16'h4014, 8'h77, 1'b1, 1'b0);
    checks++;
    if (bus_addr !== 16'h4014 || bus_ren !== 1'b1 || bus_wen !== 1'b0 ||
        cpu_rdata !== mem_f(16'h4014) || cpu_rdy !== 1'b1) begin
      errors++;
      $display("FAIL pass_read: addr=%h ren=%b wen=%b rdata=%h rdy=%b required 4014 1 0 %h 1",
               bus_addr, bus_ren, bus_wen, cpu_rdata, cpu_rdy, mem_f(16'h4014));
    end
    drive_cycle(1'b1, 16'h4015, 8'h02, 1'b0, 1'b1);
    checks++;
    if (bus_addr !== 16'h4015 || bus_wdata !== 8'h02 || bus_ren !== 1'b0 || bus_wen !== 1'b1) begin
      errors++;
      $display("FAIL pass_write: addr=%h wdata=%h ren=%b wen=%b required 4015 02 0 1",
               bus_addr, bus_wdata, bus_ren, bus_wen);
    end
    drive_cycle(1'b1, 16'h0000, 8'h00, 1'b0, 1'b0);
    checks++;
    if (dma_busy !== 1'b0 || cpu_rdy !== 1'b1 || bus_ren !== 1'b0 || bus_wen !== 1'b0) begin
      errors++;
      $display("FAIL pass_no_dma: busy=%b rdy=%b ren=%b wen=%b required 0 1 0 0",
               dma_busy, cpu_rdy, bus_ren, bus_wen);
    end
  endtask

  // Launch one burst and follow it clock by clock against the expected
  // HALT [ALIGN] (READ WRITE)x256 sequence.
  task automatic run_burst(input logic [7:0] page, input bit want_align,
                           input int period, input string tag);
    int   len;
    int   e;
    int   k;
    int   j;
    int   i;
    bit   done;
    logic en;
    logic exp_ren;
    logic exp_wen;
    logic [15:0] exp_addr;
    logic [7:0]  exp_wd;
    bit   bad;

    len = want_align ? 514 : 513;
    // Trigger parity flips on the trigger cycle itself.
    if (par_m != (want_align ? 1'b0 : 1'b1))
      drive_cycle(1'b1, 16'h0000, 8'h00, 1'b0, 1'b0);

    drive_cycle(1'b1, 16'h4014, page, 1'b0, 1'b1);
    checks++;
    if (bus_wen !== 1'b1 || bus_addr !== 16'h4014 || bus_wdata !== page || cpu_rdy !== 1'b1) begin
      errors++;
      $display("FAIL %s trigger_pass: wen=%b addr=%h wdata=%h rdy=%b required 1 4014 %h 1",
               tag, bus_wen, bus_addr, bus_wdata, cpu_rdy, page);
    end

    e = 0; k = 0; done = 1'b0;
    exp_addr = 16'h0000; exp_wd = 8'h00;
    while (!done && k < period * (len + 4)) begin
      en = ((k % period) == (period - 1));
      // CPU keeps hammering the DMA register; it must stay blocked.
      drive_cycle(en, 16'h4014, 8'h55, en, en);
      if (dma_busy === 1'b0) begin
        done = 1'b1;
        checks++;
        if (cpu_rdy !== 1'b1) begin
          errors++;
          $display("FAIL %s end_rdy: cpu_rdy=%b required 1", tag, cpu_rdy);
        end
        cyc_en = 1'b0; cpu_ren = 1'b0; cpu_wen = 1'b0;
        if (en) par_m = ~par_m;
      end else if (!en) begin
        checks++;
        if (bus_ren !== 1'b0 || bus_wen !== 1'b0 || cpu_rdy !== 1'b0) begin
          errors++;
          $display("FAIL %s idle_clk k=%0d: ren=%b wen=%b rdy=%b required 0 0 0",
                   tag, k, bus_ren, bus_wen, cpu_rdy);
        end
      end else begin
        checks++;
        if (e >= len) begin
          errors++;
          $display("FAIL %s overrun: busy_cycles=%0d required %0d", tag, e + 1, len);
        end else begin
          if (e == 0 || (want_align && e == 1)) begin
            exp_ren = 1'b0; exp_wen = 1'b0;
          end else begin
            j = e - 1 - (want_align ? 1 : 0);
            i = j / 2;
            if (j % 2 == 0) begin
              exp_ren = 1'b1; exp_wen = 1'b0; exp_addr = {page, 8'(i)};
            end else begin
              exp_ren = 1'b0; exp_wen = 1'b1; exp_addr = 16'h2004;
              exp_wd  = mem_f({page, 8'(i)});
            end
          end
          bad = ({bus_ren, bus_wen, cpu_rdy, dma_busy} !== {exp_ren, exp_wen, 1'b0, 1'b1});
          if ((exp_ren || exp_wen) && bus_addr !== exp_addr) bad = 1'b1;
          if (exp_wen && bus_wdata !== exp_wd) bad = 1'b1;
          if (bad) begin
            errors++;
            $display("FAIL %s step %0d: ren=%b wen=%b rdy=%b busy=%b addr=%h wdata=%h required %b %b 0 1 %h %h",
                     tag, e, bus_ren, bus_wen, cpu_rdy, dma_busy, bus_addr, bus_wdata,
                     exp_ren, exp_wen, exp_addr, exp_wd);
          end
        end
        e++;
      end
      k++;
    end
    checks++;
    if (!done || e != len) begin
      errors++;
      $display("FAIL %s burst_len: cycles=%0d returned=%0d required %0d 1", tag, e, done, len);
    end
  endtask

  task automatic test_burst_no_align;
    run_burst(8'h02, 1'b0, 1, "no_align");
  endtask

  task automatic test_burst_align;
    run_burst(8'h02, 1'b1, 1, "align");
  endtask

  task automatic test_sparse_enable;
    run_burst(8'h02, 1'b0, 3, "every3");
  endtask

  task automatic test_page_wrap;
    run_burst(8'hFF, 1'b1, 1, "page_ff");
    // A fresh trigger afterwards must start again from index 0 of the new page.
    run_burst(8'h10, 1'b0, 1, "after_wrap");
  endtask

  task automatic test_reset_mid_burst;
    bit hit;
    int strobes;
    drive_cycle(1'b1, 16'h4014, 8'h03, 1'b0, 1'b1);
    hit = 1'b0;
    for (int k = 0; k < 300 && !hit; k++) begin
      drive_cycle(1'b1, 16'h0000, 8'h00, 1'b0, 1'b0);
      if (bus_ren === 1'b1 && bus_addr === 16'h0340) hit = 1'b1;
    end
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL rst_mid reach_idx40: read of 0340 seen=%b required 1", hit);
    end
    cyc_en = 1'b0;
    rst = 1'b0;
    #1;
    checks++;
    if (cpu_rdy !== 1'b1 || dma_busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid immediate: cpu_rdy=%b dma_busy=%b required 1 0", cpu_rdy, dma_busy);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1; par_m = 1'b0;
    strobes = 0;
    for (int k = 0; k < 600; k++) begin
      drive_cycle(1'b1, 16'h0000, 8'h00, 1'b0, 1'b0);
      if (bus_ren !== 1'b0 || bus_wen !== 1'b0 || cpu_rdy !== 1'b1 || dma_busy !== 1'b0)
        strobes++;
    end
    checks++;
    if (strobes != 0) begin
      errors++;
      $display("FAIL rst_mid after_release: bad_cycles=%0d required 0", strobes);
    end
  endtask

  initial begin
    rst = 1'b0; cyc_en = 1'b0; cpu_addr = 16'h0000; cpu_wdata = 8'h00;
    cpu_ren = 1'b0; cpu_wen = 1'b0;
    test_reset;
    test_passthrough;
    test_burst_no_align;
    test_burst_align;
    test_sparse_enable;
    test_page_wrap;
    test_reset_mid_burst;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/oam_dma_ctrl.md
OAM_DMA_CTRL -- requirements
Module: oam_dma_ctrl

Interface
REQ-001 SHALL have parameter DMA_REG_ADDR, default 16'h4014, meaning CPU write address that triggers DMA.
REQ-002 SHALL have parameter OAM_DATA_ADDR, default 16'h2004, meaning PPU OAM data port targeted by DMA writes.
REQ-003 SHALL have parameter XFER_LEN, default 256, meaning bytes per DMA burst.
REQ-004 SHALL have port clk, input, 1, the single system clock; all state changes on its rising edge.
REQ-005 SHALL have port rst, input, 1, reset: asynchronous, active-low (asserted when 0).
REQ-006 SHALL have port cyc_en, input, 1, one-clk pulse marking a CPU bus cycle; the block advances only when high.
REQ-007 SHALL have port cpu_addr, input, 16, CPU address.
REQ-008 SHALL have port cpu_wdata, input, 8, CPU write data.
REQ-009 SHALL have ports cpu_ren and cpu_wen, input, 1 each, CPU read and write strobes.
REQ-010 SHALL have port cpu_rdata, output, 8, read data returned to CPU.
REQ-011 SHALL have port cpu_rdy, output, 1, CPU ready; low halts the CPU.
REQ-012 SHALL have ports bus_addr (16), bus_wdata (8), bus_ren (1), bus_wen (1), all outputs, driving the shared memory bus.
REQ-013 SHALL have port bus_rdata, input, 8, shared-bus read data.
REQ-014 SHALL have port dma_busy, output, 1, high from HALT entry until the last DMA write completes.

Function
REQ-015 SHALL implement states IDLE, HALT, ALIGN, READ, WRITE; all transitions qualified by cyc_en.
REQ-016 In IDLE the bus outputs SHALL mirror the CPU inputs combinationally, cpu_rdata SHALL equal bus_rdata, and cpu_rdy SHALL be 1.
REQ-017 In IDLE, cyc_en & cpu_wen & cpu_addr==DMA_REG_ADDR SHALL latch page<=cpu_wdata, clear idx to 0, and enter HALT. The triggering write itself SHALL pass to the bus.
REQ-018 In HALT, ALIGN, READ and WRITE, cpu_rdy SHALL be 0, the block SHALL own the bus, and CPU strobes SHALL be blocked.
REQ-019 A 1-bit parity flop SHALL toggle on every cyc_en (reset 0).
REQ-020 From HALT the block SHALL go to ALIGN if parity==1 at that cycle, else to READ. ALIGN SHALL last one cycle, with no bus strobes, then go to READ.
REQ-021 In READ: bus_addr={page,idx}, bus_ren=1; bus_rdata SHALL be latched into a data register at the end of the cycle; next state WRITE.
REQ-022 In WRITE: bus_addr=OAM_DATA_ADDR, bus_wdata=data register, bus_wen=1; idx increments with 8-bit wrap. If idx==XFER_LEN-1, next state SHALL be IDLE, otherwise READ.
REQ-023 Burst length SHALL be 513 cyc_en cycles (no ALIGN) or 514 cycles (with ALIGN), counted from HALT entry to the first cycle back in IDLE.
REQ-024 Writes to DMA_REG_ADDR while not IDLE SHALL be ignored, since CPU strobes are blocked.
REQ-025 When cyc_en is low, state, idx, page and data SHALL hold and no bus strobe SHALL assert.
REQ-026 Source reads SHALL stay within the page {page,8'h00}..{page,8'hFF}; no carry into page.

Reset
REQ-027 On rst==0, asynchronously: state=IDLE, page=0, idx=0, data=0, parity=0; cpu_rdy=1, dma_busy=0, bus strobes follow CPU (IDLE mirror).
REQ-028 Reset mid-burst SHALL abort the burst with no further DMA strobes; the CPU resumes after release.

Structure
REQ-029 The state enum, DMA_REG_ADDR and OAM_DATA_ADDR defaults SHALL live in shared package nes_pkg.
REQ-030 The bus ownership mux SHALL be sub-module cpu_bus_mux (select, CPU side, DMA side, bus side); the FSM, counters and registers stay in oam_dma_ctrl.

Verification
REQ-031 Bench SHALL check: parity=0, CPU writes 8'h02 to 16'h4014 -> reads 16'h0200..16'h02FF, each followed by a write to 16'h2004 with the matching byte; 513 cycles; cpu_rdy low throughout.
REQ-032 Bench SHALL check: same trigger with parity=1 -> one ALIGN cycle with no strobes; 514 cycles total.
REQ-033 Bench SHALL check: cyc_en asserted every 3rd clk -> identical bus sequence; no strobes on non-enable clocks.
REQ-034 Bench SHALL check: rst pulsed low at idx=8'h40 -> cpu_rdy=1 and dma_busy=0 immediately; no DMA strobes after release.
REQ-035 Bench SHALL check: CPU read of 16'h4014 and write to 16'h4015 in IDLE -> plain passthrough, no DMA.
REQ-036 Bench SHALL check: page 8'hFF -> last read at 16'hFFFF, idx wraps to 0, return to IDLE.
